// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: opcode-driven format decode, sign extension,
// CSR zimm, illegal-opcode flag and pc+imm target, behind a valid/ready elastic pipeline.
module imm_gen_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PIPE_STAGES = 1,
  parameter bit          EN_ZIMM     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FmtU       = 3'd0,
    FmtJ       = 3'd1,
    FmtI       = 3'd2,
    FmtS       = 3'd3,
    FmtB       = 3'd4,
    FmtZ       = 3'd5,
    FmtNone    = 3'd6,
    FmtIllegal = 3'd7
  } fmt_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;

  // Payload layout: {imm, fmt, pc, target, illegal}
  localparam int unsigned PayW = 3 * XLEN + 4;

  fmt_e            w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_target;
  logic            w_illegal;
  logic [PayW-1:0] w_dec;

  always_comb begin
    w_fmt = FmtIllegal;
    case (in_inst[6:0])
      OpLui, OpAuipc:          w_fmt = FmtU;
      OpJal:                   w_fmt = FmtJ;
      OpJalr, OpLoad, OpOpImm: w_fmt = FmtI;
      OpStore:                 w_fmt = FmtS;
      OpBranch:                w_fmt = FmtB;
      OpSystem:                w_fmt = (EN_ZIMM && in_inst[14]) ? FmtZ : FmtI;
      OpOp, OpFence:           w_fmt = FmtNone;
      default:                 w_fmt = FmtIllegal;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FmtU: w_imm32 = {in_inst[31:12], 12'b0};
      FmtJ: w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                       in_inst[30:21], 1'b0};
      FmtI: w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FmtS: w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FmtB: w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                       in_inst[11:8], 1'b0};
      FmtZ: w_imm32 = {27'b0, in_inst[19:15]};
      default: w_imm32 = '0;
    endcase
  end

  // Z has bit 31 clear, so one signed widening covers every format at XLEN=64.
  assign w_imm     = XLEN'($signed(w_imm32));
  assign w_target  = in_pc + w_imm;
  assign w_illegal = (w_fmt == FmtIllegal);
  assign w_dec     = {w_imm, w_fmt, in_pc, w_target, w_illegal};

  logic            r_s1_valid;
  logic [PayW-1:0] r_s1_data;
  logic            w_s1_ready;
  logic            w_s1_next_ready;
  logic            w_accept;
  logic [PayW-1:0] w_out_data;

  assign w_s1_ready = !r_s1_valid | w_s1_next_ready;
  assign in_ready   = w_s1_ready & !flush;
  assign w_accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_s1_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_data <= w_dec;
      end
    end
  end

  if (PIPE_STAGES == 2) begin : g_s2
    logic            r_s2_valid;
    logic [PayW-1:0] r_s2_data;
    logic            w_s2_ready;

    assign w_s2_ready = !r_s2_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_valid <= 1'b0;
        r_s2_data  <= '0;
      end else begin
        if (flush) begin
          r_s2_valid <= 1'b0;
        end else if (w_s2_ready) begin
          r_s2_valid <= r_s1_valid;
        end
        if (w_s2_ready && r_s1_valid) begin
          r_s2_data <= r_s1_data;
        end
      end
    end

    assign w_s1_next_ready = w_s2_ready;
    assign out_valid       = r_s2_valid;
    assign w_out_data      = r_s2_data;
  end else begin : g_s1_only
    assign w_s1_next_ready = out_ready;
    assign out_valid       = r_s1_valid;
    assign w_out_data      = r_s1_data;
  end

  assign {out_imm, out_fmt, out_pc, out_target, out_illegal} = w_out_data;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit two-stage instance with zimm and a 64-bit
// single-stage instance without zimm, plus backpressure, flush and async-reset sequences.
module tb_imm_gen_pipe;

  localparam int PipeA = 2;
  localparam int PipeB = 1;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_illegal_a;
  logic [31:0] in_inst_a, in_pc_a, out_imm_a, out_pc_a, out_target_a;
  logic [2:0]  out_fmt_a;

  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_illegal_b;
  logic [31:0] in_inst_b;
  logic [63:0] in_pc_b, out_imm_b, out_pc_b, out_target_b;
  logic [2:0]  out_fmt_b;

  imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(PipeA), .EN_ZIMM(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_inst(in_inst_a), .in_pc(in_pc_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_imm(out_imm_a),
    .out_fmt(out_fmt_a), .out_pc(out_pc_a), .out_target(out_target_a),
    .out_illegal(out_illegal_a)
  );

  imm_gen_pipe #(.XLEN(64), .PIPE_STAGES(PipeB), .EN_ZIMM(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_inst(in_inst_b), .in_pc(in_pc_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_imm(out_imm_b),
    .out_fmt(out_fmt_b), .out_pc(out_pc_b), .out_target(out_target_b),
    .out_illegal(out_illegal_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_one_a(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    out_ready_a = 1'b1;
    in_valid_a  = 1'b1;
    in_inst_a   = v.inst;
    in_pc_a     = v.pc[31:0];
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready_a), 64'd1);
    @(negedge clk);
    in_valid_a = 1'b0;
    lat = 1;
    while (!out_valid_a && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    #1;
    chk({tag, "_latency"}, 64'(lat), 64'(PipeA));
    chk({tag, "_fmt"}, 64'(out_fmt_a), 64'(v.fmt));
    chk({tag, "_imm"}, 64'(out_imm_a), v.imm);
    chk({tag, "_pc"}, 64'(out_pc_a), v.pc);
    chk({tag, "_target"}, 64'(out_target_a), v.tgt);
    chk({tag, "_illegal"}, 64'(out_illegal_a), 64'(v.ill));
  endtask

  task automatic run_one_b(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    in_valid_b = 1'b1;
    in_inst_b  = v.inst;
    in_pc_b    = v.pc;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready_b), 64'd1);
    @(negedge clk);
    in_valid_b = 1'b0;
    lat = 1;
    while (!out_valid_b && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    #1;
    chk({tag, "_latency"}, 64'(lat), 64'(PipeB));
    chk({tag, "_fmt"}, 64'(out_fmt_b), 64'(v.fmt));
    chk({tag, "_imm"}, out_imm_b, v.imm);
    chk({tag, "_pc"}, out_pc_b, v.pc);
    chk({tag, "_target"}, out_target_b, v.tgt);
    chk({tag, "_illegal"}, 64'(out_illegal_b), 64'(v.ill));
  endtask

  // addi x1, x0, k
  function automatic logic [31:0] addi(input int k);
    return {12'(k), 5'd0, 3'b000, 5'd1, 7'h13};
  endfunction

  task automatic backpressure();
    int  sent = 0;
    int  rcvd = 0;
    bit  saw_block = 1'b0;
    bit  stalled_prev = 1'b0;
    logic [31:0] e_pc;
    for (int c = 0; c < 30 && rcvd < 4; c++) begin
      @(negedge clk);
      out_ready_a = (c >= 5);
      in_valid_a  = (sent < 4);
      in_inst_a   = addi(sent + 1);
      in_pc_a     = 32'h1000 + 32'(4 * sent);
      #1;
      if (stalled_prev) chk("bp_hold_valid", 64'(out_valid_a), 64'd1);
      if (out_valid_a) begin
        e_pc = 32'h1000 + 32'(4 * rcvd);
        chk("bp_imm", 64'(out_imm_a), 64'(rcvd + 1));
        chk("bp_pc", 64'(out_pc_a), 64'(e_pc));
        chk("bp_target", 64'(out_target_a), 64'(e_pc + 32'(rcvd + 1)));
      end
      if (in_valid_a && !in_ready_a) saw_block = 1'b1;
      if (in_valid_a && in_ready_a) sent++;
      if (out_valid_a && out_ready_a) rcvd++;
      stalled_prev = out_valid_a && !out_ready_a;
    end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    chk("bp_received", 64'(rcvd), 64'd4);
    chk("bp_in_ready_dropped", 64'(saw_block), 64'd1);
    @(negedge clk);
    #1;
    chk("bp_no_duplicate", 64'(out_valid_a), 64'd0);
  endtask

  vec_t va[13];
  vec_t vb[4];

  initial begin
    va[0]  = '{32'h0080006F, 64'h100,      3'd1, 64'h8,        64'h108,      1'b0};
    va[1]  = '{32'hFE000EE3, 64'h0,        3'd4, 64'hFFFFFFFC, 64'hFFFFFFFC, 1'b0};
    va[2]  = '{32'h12345037, 64'h1000,     3'd0, 64'h12345000, 64'h12346000, 1'b0};
    va[3]  = '{32'h3401D073, 64'h200,      3'd5, 64'h3,        64'h203,      1'b0};
    va[4]  = '{32'h0000007F, 64'h40,       3'd7, 64'h0,        64'h40,       1'b1};
    va[5]  = '{32'hFFF00093, 64'h10,       3'd2, 64'hFFFFFFFF, 64'hF,        1'b0};
    va[6]  = '{32'h00112423, 64'h20,       3'd3, 64'h8,        64'h28,       1'b0};
    va[7]  = '{32'h002081B3, 64'h30,       3'd6, 64'h0,        64'h30,       1'b0};
    va[8]  = '{32'hFFFFF117, 64'h2000,     3'd0, 64'hFFFFF000, 64'h1000,     1'b0};
    va[9]  = '{32'h34011073, 64'h0,        3'd2, 64'h340,      64'h340,      1'b0};
    va[10] = '{32'h0FF0000F, 64'h50,       3'd6, 64'h0,        64'h50,       1'b0};
    va[11] = '{32'h00209463, 64'h7FFFFFFC, 3'd4, 64'h8,        64'h80000004, 1'b0};
    va[12] = '{32'h00000000, 64'h60,       3'd7, 64'h0,        64'h60,       1'b1};

    vb[0] = '{32'h80000037, 64'h0, 3'd0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0};
    vb[1] = '{32'h3401D073, 64'h100, 3'd2, 64'h340, 64'h440, 1'b0};
    vb[2] = '{32'hFE000EE3, 64'h0, 3'd4, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vb[3] = '{32'h0080006F, 64'hFFFFFFFFFFFFFFFC, 3'd1, 64'h8, 64'h4, 1'b0};

    rst_n = 1'b0;
    flush_a = 1'b0; in_valid_a = 1'b0; in_inst_a = '0; in_pc_a = '0; out_ready_a = 1'b1;
    flush_b = 1'b0; in_valid_b = 1'b0; in_inst_b = '0; in_pc_b = '0; out_ready_b = 1'b1;

    #2;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_out_imm", 64'(out_imm_a), 64'd0);
    chk("rst_out_fmt", 64'(out_fmt_a), 64'd0);
    chk("rst_out_pc", 64'(out_pc_a), 64'd0);
    chk("rst_out_target", 64'(out_target_a), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal_a), 64'd0);
    chk("rst_b_out_valid", 64'(out_valid_b), 64'd0);

    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready_a), 64'd1);
    chk("rel_b_in_ready", 64'(in_ready_b), 64'd1);

    for (int i = 0; i < 13; i++) run_one_a(va[i], $sformatf("a%0d", i));
    for (int i = 0; i < 4; i++) run_one_b(vb[i], $sformatf("b%0d", i));

    backpressure();

    // Flush with both stages full and a new input offered.
    @(negedge clk);
    out_ready_a = 1'b0; in_valid_a = 1'b1; in_inst_a = addi(5); in_pc_a = 32'h3000;
    @(negedge clk);
    in_inst_a = addi(6); in_pc_a = 32'h3004;
    @(negedge clk);
    flush_a = 1'b1; in_inst_a = addi(7); in_pc_a = 32'h3008;
    #1;
    chk("fl_in_ready", 64'(in_ready_a), 64'd0);
    chk("fl_full_before", 64'(out_valid_a), 64'd1);
    @(negedge clk);
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    #1;
    chk("fl_out_valid", 64'(out_valid_a), 64'd0);
    run_one_a(va[0], "fl_next");
    @(negedge clk);
    #1;
    chk("fl_drained", 64'(out_valid_a), 64'd0);

    // Asynchronous reset asserted between clock edges.
    @(negedge clk);
    out_ready_a = 1'b0; in_valid_a = 1'b1; in_inst_a = addi(9); in_pc_a = 32'h4000;
    @(negedge clk);
    in_inst_a = addi(10); in_pc_a = 32'h4004;
    @(negedge clk);
    in_valid_a = 1'b0;
    #1;
    chk("ar_full_before", 64'(out_valid_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid_a), 64'd0);
    chk("ar_out_imm", 64'(out_imm_a), 64'd0);
    chk("ar_out_pc", 64'(out_pc_a), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready_a = 1'b1;
    #1;
    chk("ar_in_ready", 64'(in_ready_a), 64'd1);
    chk("ar_out_valid_after", 64'(out_valid_a), 64'd0);
    run_one_a(va[1], "ar_next");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
